// File: rtl/mux_ndff_pkg.sv
// Shared constants for the MUX-recirculation synchronizer slice.
package mux_ndff_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Fewer than two flops gives no metastability margin; more than four only adds latency.
  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/mux_ndff_pulse_sync_if.sv
// Bus between the source-domain producer (en/data) and the destination-side synchronizer.
interface mux_ndff_pulse_sync_if
  import mux_ndff_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  en;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] data_sync;
  logic                  data_valid;

  // Source side: presents the qualified data word, observes the synchronized copy.
  modport master (
    output en,
    output data,
    input  data_sync,
    input  data_valid
  );

  // Destination side: the synchronizer itself.
  modport slave (
    input  en,
    input  data,
    output data_sync,
    output data_valid
  );

endinterface

// File: rtl/ndff_sync.sv
// N-stage single-bit synchronizer with asynchronous active-high reset.
// The chain is a pure shift register: no logic between stages.
module ndff_sync
  import mux_ndff_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  assign sync_d = {sync_q[STAGES-2:0], d_i};

  // Shift the asynchronous level one stage per clock; clear the whole chain on reset.
  // NOTE: non-blocking assignments let every stage sample the previous stage's old value,
  // so the chain really is STAGES flops deep rather than collapsing into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mux_ndff_pulse_sync.sv
// Destination half of a MUX-recirculation CDC synchronizer.
// Only the enable level crosses through flops; its synchronized rising edge
// becomes a one-cycle load pulse that captures the (by then stable) data bus.
module mux_ndff_pulse_sync
  import mux_ndff_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int                    SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                 clkb,
  input  logic                 rstb,
  mux_ndff_pulse_sync_if.slave bus
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
    $error("mux_ndff_pulse_sync: SYNC_STAGES must lie in 2..4");
  end

  logic                  en_sync;
  logic                  en_d_q;
  logic                  load;
  logic [DATA_WIDTH-1:0] data_sync_q;
  logic [DATA_WIDTH-1:0] data_sync_d;
  logic                  data_valid_q;

  ndff_sync #(
    .STAGES (SYNC_STAGES)
  ) u_en_sync (
    .clk (clkb),
    .rst (rstb),
    .d_i (bus.en),
    .q_o (en_sync)
  );

  // Rising-edge detect: one pulse per synchronized en assertion, however long en stays high.
  assign load = en_sync & ~en_d_q;

  // Recirculating mux: take the source bus on load, otherwise hold the current word.
  // NOTE: the hold path is written explicitly so every path assigns data_sync_d and no latch forms.
  always_comb begin
    data_sync_d = data_sync_q;
    if (load) begin
      data_sync_d = bus.data;
    end
  end

  // Edge-detect delay flop, holding register and its one-cycle valid strobe.
  always_ff @(posedge clkb or posedge rstb) begin
    if (rstb) begin
      en_d_q       <= 1'b0;
      data_sync_q  <= RESET_VALUE;
      data_valid_q <= 1'b0;
    end else begin
      en_d_q       <= en_sync;
      data_sync_q  <= data_sync_d;
      data_valid_q <= load;
    end
  end

  assign bus.data_sync  = data_sync_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_mux_ndff_pulse_sync.sv
// Directed bench for mux_ndff_pulse_sync: three instances (SYNC_STAGES = 2, 3, 4)
// share one en/data stimulus; latency, data capture and pulse counts are
// checked against hand-computed values.
module tb_mux_ndff_pulse_sync;

  localparam int NDUT = 3;
  localparam int NS [NDUT] = '{2, 3, 4};

  logic       clk;
  logic       rstb;
  logic       en;
  logic [7:0] data;

  int tests_run;
  int tests_failed;

  mux_ndff_pulse_sync_if #(.DATA_WIDTH(8)) if2 ();
  mux_ndff_pulse_sync_if #(.DATA_WIDTH(8)) if3 ();
  mux_ndff_pulse_sync_if #(.DATA_WIDTH(8)) if4 ();

  assign if2.en = en;  assign if2.data = data;
  assign if3.en = en;  assign if3.data = data;
  assign if4.en = en;  assign if4.data = data;

  mux_ndff_pulse_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2), .RESET_VALUE(8'h00)) u_dut2 (
    .clkb (clk), .rstb (rstb), .bus (if2.slave));
  mux_ndff_pulse_sync #(.DATA_WIDTH(8), .SYNC_STAGES(3), .RESET_VALUE(8'h00)) u_dut3 (
    .clkb (clk), .rstb (rstb), .bus (if3.slave));
  mux_ndff_pulse_sync #(.DATA_WIDTH(8), .SYNC_STAGES(4), .RESET_VALUE(8'h00)) u_dut4 (
    .clkb (clk), .rstb (rstb), .bus (if4.slave));

  logic [7:0] ds [NDUT];
  logic       dv [NDUT];
  assign ds[0] = if2.data_sync;  assign dv[0] = if2.data_valid;
  assign ds[1] = if3.data_sync;  assign dv[1] = if3.data_valid;
  assign ds[2] = if4.data_sync;  assign dv[2] = if4.data_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: a one-cycle data_valid spans exactly one falling edge.
  int pulses [NDUT];
  initial for (int i = 0; i < NDUT; i++) pulses[i] = 0;
  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) if (dv[i] === 1'b1) pulses[i] = pulses[i] + 1;
  end

  int base [NDUT];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic snap_pulses();
    for (int i = 0; i < NDUT; i++) base[i] = pulses[i];
  endtask

  task automatic check_pulses(input string tag, input int exp);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("%s_pulses_n%0d", tag, NS[i]), pulses[i] - base[i], exp);
  endtask

  task automatic check_data(input string tag, input logic [7:0] exp);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("%s_data_n%0d", tag, NS[i]), {24'h0, ds[i]}, {24'h0, exp});
  endtask

  // Counts edges from the first en sample (edge 1) until data_valid is seen;
  // a load at edge k+N appears at index N+1. Budget of 12 edges; 0 means never seen.
  task automatic measure(input string tag, input logic [7:0] exp_data);
    int first [NDUT];
    for (int i = 0; i < NDUT; i++) first[i] = 0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (dv[i] === 1'b1 && first[i] == 0) first[i] = j;
    end
    for (int i = 0; i < NDUT; i++)
      check($sformatf("%s_latency_n%0d", tag, NS[i]), first[i], NS[i] + 1);
    check_data(tag, exp_data);
  endtask

  // Raise en at a random phase within the clock period, then measure.
  task automatic raise_and_measure(input string tag, input logic [7:0] d);
    @(posedge clk);
    #($urandom_range(1, 9));
    data = d;
    en   = 1'b1;
    measure(tag, d);
  endtask

  initial begin
    logic [7:0] rnd;
    tests_run    = 0;
    tests_failed = 0;
    rstb = 1'b1;
    en   = 1'b0;
    data = 8'h00;

    // Reset state
    #12;
    check_data("reset", 8'h00);
    for (int i = 0; i < NDUT; i++) check($sformatf("reset_valid_n%0d", NS[i]), dv[i], 1'b0);
    @(negedge clk) rstb = 1'b0;
    repeat (3) @(negedge clk);

    // Basic transfer
    snap_pulses();
    raise_and_measure("basic", 8'h55);
    @(negedge clk) en = 1'b0;
    check_pulses("basic", 1);

    // Back-to-back after three low cycles
    repeat (3) @(negedge clk);
    raise_and_measure("b2b", 8'hFF);
    @(negedge clk) en = 1'b0;
    check_pulses("b2b_total", 2);

    // Data toggling while en is low is ignored
    repeat (6) @(negedge clk);
    snap_pulses();
    for (int c = 0; c < 10; c++) begin
      data = c[0] ? 8'h3C : 8'h00;
      @(negedge clk);
      check($sformatf("ignored_hold_c%0d", c), {24'h0, ds[0]}, 32'hFF);
    end
    check_data("ignored_end", 8'hFF);
    check_pulses("ignored", 0);

    // Long enable: one pulse only
    repeat (3) @(negedge clk);
    snap_pulses();
    data = 8'hA5;
    en   = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) check_data("long_mid", 8'hA5);
    end
    check_data("long_end", 8'hA5);
    check_pulses("long", 1);
    en = 1'b0;

    // Reset mid-transfer with en high; en still high at release is a new edge
    repeat (6) @(negedge clk);
    data = 8'hAA;
    en   = 1'b1;
    @(posedge clk);
    #3 rstb = 1'b1;
    #1;
    check_data("rst_mid", 8'h00);
    for (int i = 0; i < NDUT; i++) check($sformatf("rst_mid_valid_n%0d", NS[i]), dv[i], 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #4 rstb = 1'b0;
    snap_pulses();
    measure("rst_release", 8'hAA);
    check_pulses("rst_release", 1);
    @(negedge clk) en = 1'b0;

    // Random-phase latency sweep across all stage counts
    for (int it = 0; it < 4; it++) begin
      repeat (6) @(negedge clk);
      rnd = 8'($urandom_range(0, 255));
      raise_and_measure($sformatf("sweep%0d", it), rnd);
      @(negedge clk) en = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
